// File: rtl/mem_bus_arbiter.sv
// Single-port CPU memory bus arbiter for fetch, execute and OAM DMA; halts the CPU while DMA owns the bus.
// Optional macro STARVE_GUARD_EN promotes a starved fetch over execute after STARVE_LIMIT denials.
module mem_bus_arbiter
`ifdef STARVE_GUARD_EN
  #(parameter int STARVE_LIMIT = 4)
`endif
(
  input  logic        clk,
  input  logic        reset_n,

  input  logic        fetch_req,
  input  logic [15:0] fetch_addr,
  output logic        fetch_gnt,
  output logic        fetch_ack,

  input  logic        exec_req,
  input  logic        exec_we,
  input  logic [15:0] exec_addr,
  input  logic [7:0]  exec_wdata,
  output logic        exec_gnt,
  output logic        exec_ack,

  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic        dma_gnt,
  output logic        dma_ack,

  output logic        cpu_halt,

  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  rdata
);

  typedef enum logic [1:0] {
    ST_CPU       = 2'd0,
    ST_DMA_ALIGN = 2'd1,
    ST_DMA_RUN   = 2'd2
  } state_e;

  state_e      r_state;
  state_e      w_state_nxt;
  logic        r_fetch_ack;
  logic        r_exec_ack;
  logic        r_dma_ack;
  logic        r_cpu_halt;
  logic [15:0] r_addr_hold;

  logic        w_fetch_win;
  logic        w_exec_win;
  logic        w_dma_win;
  logic        w_fetch_issue;
  logic        w_exec_issue;
  logic        w_dma_issue;
  logic        w_fetch_promote;

`ifdef STARVE_GUARD_EN
  localparam int                 CNT_W     = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]   CNT_LIMIT = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

  logic [CNT_W-1:0] r_starve_cnt;

  // Counts only in CPU state so a DMA burst neither ages nor forgives a waiting fetch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_starve_cnt <= '0;
    end else if (r_state == ST_CPU) begin
      if (w_fetch_issue) begin
        r_starve_cnt <= '0;
      end else if (fetch_req && (r_starve_cnt != CNT_MAX)) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end
    end
  end

  assign w_fetch_promote = (r_starve_cnt >= CNT_LIMIT);
`else
  assign w_fetch_promote = 1'b0;
`endif

  // NOTE: every variable written here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_fetch_win = 1'b0;
    w_exec_win  = 1'b0;
    w_dma_win   = 1'b0;
    case (r_state)
      ST_CPU: begin
        if (exec_req && !(w_fetch_promote && fetch_req)) begin
          w_exec_win = 1'b1;
        end else if (fetch_req) begin
          w_fetch_win = 1'b1;
        end
        if (dma_req) begin
          w_state_nxt = ST_DMA_ALIGN;
        end
      end
      ST_DMA_ALIGN: begin
        w_state_nxt = ST_DMA_RUN;
      end
      ST_DMA_RUN: begin
        w_dma_win = dma_req;
        if (!dma_req) begin
          w_state_nxt = ST_CPU;
        end
      end
      default: begin
        w_state_nxt = ST_CPU;
      end
    endcase
  end

  // Grants are combinational from requests, so they must also be masked while reset is held.
  assign w_fetch_issue = w_fetch_win & reset_n;
  assign w_exec_issue  = w_exec_win  & reset_n;
  assign w_dma_issue   = w_dma_win   & reset_n;

  always_comb begin
    mem_addr  = r_addr_hold;
    mem_we    = 1'b0;
    mem_wdata = 8'h00;
    if (w_dma_issue) begin
      mem_addr  = dma_addr;
      mem_we    = dma_we;
      mem_wdata = dma_we ? dma_wdata : 8'h00;
    end else if (w_exec_issue) begin
      mem_addr  = exec_addr;
      mem_we    = exec_we;
      mem_wdata = exec_we ? exec_wdata : 8'h00;
    end else if (w_fetch_issue) begin
      mem_addr  = fetch_addr;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_CPU;
      r_cpu_halt  <= 1'b0;
      r_fetch_ack <= 1'b0;
      r_exec_ack  <= 1'b0;
      r_dma_ack   <= 1'b0;
      r_addr_hold <= 16'h0000;
    end else begin
      r_state     <= w_state_nxt;
      r_cpu_halt  <= (w_state_nxt != ST_CPU);
      r_fetch_ack <= w_fetch_issue;
      r_exec_ack  <= w_exec_issue;
      r_dma_ack   <= w_dma_issue;
      r_addr_hold <= mem_addr;
    end
  end

  assign fetch_gnt = w_fetch_issue;
  assign exec_gnt  = w_exec_issue;
  assign dma_gnt   = w_dma_issue;
  assign fetch_ack = r_fetch_ack;
  assign exec_ack  = r_exec_ack;
  assign dma_ack   = r_dma_ack;
  assign cpu_halt  = r_cpu_halt;
  assign rdata     = mem_rdata;

endmodule
